// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with wait states, sized access and error response
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [32:0]   diff;
    logic [31:0]   off;
    logic          in_range;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic          err;
    logic [31:0]   rd_word;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_data;
    logic [31:0]   wsh;
    logic [3:0]    be;
    logic          commit;
    logic [31:0]   rsp_rdata_d;

    // The access happens on the edge that leaves WAIT with an expired counter
    assign commit    = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign req_ready = rst_n && (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Address decode on the captured request; borrow bit catches addresses below the base
    always_comb begin
        diff     = {1'b0, adr_q} - {1'b0, BASE_ADDR};
        off      = diff[31:0];
        in_range = !diff[32] && ({1'b0, off} < RAM_BYTES);
        lane     = off[1:0];
        idx      = off[AW+1:2];
        err      = !in_range;
        case (size_q)
            2'b00:   err = !in_range;
            2'b01:   err = !in_range || lane[0];
            2'b10:   err = !in_range || (lane != 2'b00);
            default: err = 1'b1;
        endcase
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        rd_word   = mem[idx];
        byte_v    = rd_word[{lane, 3'b000} +: 8];
        half_v    = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        case (size_q)
            2'b00:   load_data = uns_q ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   load_data = uns_q ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: load_data = rd_word;
        endcase
        rsp_rdata_d = (err || we_q) ? 32'h0 : load_data;
    end

    // Store data placed on its lanes with matching byte enables
    always_comb begin
        wsh = wdata_q << {lane, 3'b000};
        be  = 4'b0000;
        case (size_q)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // RAM write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (commit && we_q && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wsh[8*b +: 8];
                end
            end
        end
    end

    // Request/response FSM with registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            adr_q       <= 32'h0;
            wdata_q     <= 32'h0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        adr_q   <= req_adr;
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        cnt_q   <= WAIT_INIT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b1;
    logic [31:0] req_adr = 32'h0, req_wdata = 32'h0;
    logic [1:0]  req_size = 2'b10;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid_z = 1'b0, req_we_z = 1'b0, req_unsigned_z = 1'b0, rsp_ready_z = 1'b1;
    logic [31:0] req_adr_z = 32'h0, req_wdata_z = 32'h0;
    logic [1:0]  req_size_z = 2'b10;
    logic        req_ready_z, rsp_valid_z, rsp_err_z;
    logic [31:0] rsp_rdata_z;

    logic [32:0] exp_q[$];
    logic [32:0] exp_qz[$];

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we_z),
        .req_adr(req_adr_z), .req_wdata(req_wdata_z), .req_size(req_size_z), .req_unsigned(req_unsigned_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [32:0] e;
        if (rsp_valid && rsp_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got err=%0b rdata=%h, required no response", rsp_err, rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== e) begin
                    n_fail++;
                    $display("FAIL rsp_data: got err=%0b rdata=%h, required err=%0b rdata=%h",
                             rsp_err, rsp_rdata, e[32], e[31:0]);
                end
            end
        end
        if (rsp_valid_z && rsp_ready_z) begin
            n_checks++;
            if (exp_qz.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected_w0: got err=%0b rdata=%h, required no response", rsp_err_z, rsp_rdata_z);
            end else begin
                e = exp_qz.pop_front();
                if ({rsp_err_z, rsp_rdata_z} !== e) begin
                    n_fail++;
                    $display("FAIL rsp_data_w0: got err=%0b rdata=%h, required err=%0b rdata=%h",
                             rsp_err_z, rsp_rdata_z, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic un, input logic [32:0] exp);
        int  acc;
        bit  ok;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        req_we = we; req_adr = adr; req_wdata = wd; req_size = sz; req_unsigned = un; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: adr=%h never accepted, required accept", adr);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rsp_timeout: adr=%h no response, required response", adr);
        end else if (cyc - acc != 1 + W) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, required %0d", cyc - acc, 1 + W);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b err=%0b rdata=%h, required 0 0 0", rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got req_ready=%0b rsp_valid=%0b, required 1 0", req_ready, rsp_valid);
        end
        issue(1'b1, 32'h10, 32'h11111111, 2'b10, 1'b0, 33'h0);
        @(posedge clk); #1;
        req_we = 1'b1; req_adr = 32'h10; req_wdata = 32'hDEADBEEF; req_size = 2'b10; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_abort: got rsp_valid=%0b rdata=%h, required 0 0", rsp_valid, rsp_rdata);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, {1'b0, 32'h11111111});
    endtask

    task automatic test_word();
        issue(1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0, 33'h0);
        issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, {1'b0, 32'h12345678});
    endtask

    task automatic test_byte_half();
        issue(1'b1, 32'h21, 32'hAAAAAA80, 2'b00, 1'b0, 33'h0);
        issue(1'b0, 32'h21, 32'h0, 2'b00, 1'b0, {1'b0, 32'hFFFFFF80});
        issue(1'b0, 32'h21, 32'h0, 2'b00, 1'b1, {1'b0, 32'h00000080});
        issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, {1'b0, 32'h12348078});
        issue(1'b1, 32'h24, 32'h0, 2'b10, 1'b0, 33'h0);
        issue(1'b1, 32'h26, 32'h5555BEEF, 2'b01, 1'b0, 33'h0);
        issue(1'b0, 32'h26, 32'h0, 2'b01, 1'b0, {1'b0, 32'hFFFFBEEF});
        issue(1'b0, 32'h26, 32'h0, 2'b01, 1'b1, {1'b0, 32'h0000BEEF});
        issue(1'b0, 32'h24, 32'h0, 2'b10, 1'b0, {1'b0, 32'hBEEF0000});
    endtask

    task automatic test_errors();
        issue(1'b0, 32'h23, 32'h0, 2'b01, 1'b0, {1'b1, 32'h0});
        issue(1'b0, 32'h22, 32'h0, 2'b10, 1'b0, {1'b1, 32'h0});
        issue(1'b0, 32'h0, 32'h0, 2'b11, 1'b0, {1'b1, 32'h0});
        issue(1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, {1'b1, 32'h0});
        issue(1'b1, 32'h22, 32'hFFFFFFFF, 2'b10, 1'b0, {1'b1, 32'h0});
        issue(1'b1, 32'h21, 32'hFFFFFFFF, 2'b01, 1'b0, {1'b1, 32'h0});
        issue(1'b1, 32'h20, 32'hFFFFFFFF, 2'b11, 1'b0, {1'b1, 32'h0});
        issue(1'b1, 32'h1000, 32'hFFFFFFFF, 2'b00, 1'b0, {1'b1, 32'h0});
        issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, {1'b0, 32'h12348078});
        issue(1'b1, 32'hFFC, 32'hA5A5A5A5, 2'b10, 1'b0, 33'h0);
        issue(1'b0, 32'hFFF, 32'h0, 2'b00, 1'b1, {1'b0, 32'h000000A5});
    endtask

    task automatic test_backpressure();
        int acc;
        bit ok;
        exp_q.push_back({1'b0, 32'h12348078});
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_we = 1'b0; req_adr = 32'h20; req_size = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 32'h11111111});
        req_adr = 32'h10;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL bp_rsp_timeout: no response, required response");
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12348078 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: got valid=%0b rdata=%h err=%0b req_ready=%0b, required 1 12348078 0 0",
                         rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_handshake_ready: got req_ready=%0b, required 0", req_ready);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle_after: got req_ready=%0b rsp_valid=%0b, required 1 0", req_ready, rsp_valid);
        end
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_second_accept: got req_ready=%0b after accept, required 0", req_ready);
        end
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || cyc - acc != 1 + W) begin
            n_fail++;
            $display("FAIL bp_second_latency: got %0d cycles (seen=%0b), required %0d", cyc - acc, ok, 1 + W);
        end
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        logic        we_t [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] adr_t[5] = '{32'h40, 32'h40, 32'h43, 32'h40, 32'h1000};
        logic [1:0]  sz_t [5] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b10};
        logic        un_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [32:0] ex_t [5] = '{33'h0, {1'b0, 32'hCAFEF00D}, {1'b0, 32'hFFFFFFCA},
                                  {1'b0, 32'h0000F00D}, {1'b1, 32'h0}};
        int k = 0;
        int nresp = 0;
        int last_acc = 0;
        bit accepted;
        @(posedge clk); #1;
        req_we_z = we_t[0]; req_adr_z = adr_t[0]; req_wdata_z = 32'hCAFEF00D;
        req_size_z = sz_t[0]; req_unsigned_z = un_t[0]; req_valid_z = 1'b1;
        exp_qz.push_back(ex_t[0]);
        for (int i = 0; i < 60 && nresp < 5; i++) begin
            @(negedge clk);
            accepted = 1'b0;
            if (rsp_valid_z) begin
                nresp++;
                n_checks++;
                if (cyc != last_acc + 1) begin
                    n_fail++;
                    $display("FAIL w0_latency: got %0d cycles, required 1", cyc - last_acc);
                end
            end
            if (req_valid_z && req_ready_z) begin
                accepted = 1'b1;
                if (k > 0) begin
                    n_checks++;
                    if (cyc + 1 - last_acc != 3) begin
                        n_fail++;
                        $display("FAIL w0_spacing: got %0d cycles between accepts, required 3", cyc + 1 - last_acc);
                    end
                end
                last_acc = cyc + 1;
                k++;
            end
            @(posedge clk); #1;
            if (accepted) begin
                if (k < 5) begin
                    req_we_z = we_t[k]; req_adr_z = adr_t[k]; req_size_z = sz_t[k]; req_unsigned_z = un_t[k];
                    exp_qz.push_back(ex_t[k]);
                end else begin
                    req_valid_z = 1'b0;
                end
            end
        end
        req_valid_z = 1'b0;
        n_checks++;
        if (nresp != 5) begin
            n_fail++;
            $display("FAIL w0_count: got %0d responses, required 5", nresp);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_errors();
        test_backpressure();
        test_back_to_back();
        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0 || exp_qz.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", exp_q.size(), exp_qz.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
